aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Parametrised AES round-sequencing controller that drives the shared AES datapath (state register, AddRoundKey, ShiftRows, SubBytes, MixColumns units) for both encryption and decryption. It supports AES-128/192/256 via the round count and a column-serial MixColumns option. It uses a round counter in place of one state per round. It outputs a round-key index to the external key-schedule store, not a flattened key vector.

Parameters:
NR, 10, rounds; legal 10/12/14; other values cause an elaboration error
MIXCOL_CYCLES, 1, cycles per MixColumns pass; legal 1/2/4; datapath processes 4/MIXCOL_CYCLES columns per cycle
RKI_W, 4, width of round-key index; must satisfy 2**RKI_W > NR

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
AES_START  in  1  level request; sampled only in IDLE and DONE
MODE  in  1  0=decrypt, 1=encrypt; captured with AES_START in IDLE
AES_DONE  out  1  result valid in state register
BUSY  out  1  high in every state except IDLE and DONE
LOAD_IN  out  1  load state register from input message
LOAD_RG  out  1  state register write enable
MSG_MUX  out  2  00 ARK, 01 (Inv)ShiftRows, 10 (Inv)MixColumns, 11 (Inv)SubBytes
COL_SEL  out  2  MixColumns slice index, 0..MIXCOL_CYCLES-1
RK_IDX  out  RKI_W  round-key index, 0..NR
RK_VALID  out  1  RK_IDX valid (ARK only)

Behaviour:
- Reset: CLK rising edge with RESET=1 forces IDLE, clears rnd, col and mode_q. Outputs are Moore-decoded from registered state; IDLE values: all outputs 0.
- States: IDLE, LOAD, ARK, SHIFT, SUB, MIX, DONE. Counters: rnd (0..NR), col (0..MIXCOL_CYCLES-1).
- IDLE: AES_START=1 -> LOAD, mode_q<=MODE, rnd<=0.
- LOAD: LOAD_IN=1, LOAD_RG=1 -> ARK (rnd=0).
- ARK: MSG_MUX=00, LOAD_RG=1, RK_VALID=1. RK_IDX = rnd when encrypting, NR-rnd when decrypting.
- SHIFT: MSG_MUX=01, LOAD_RG=1. SUB: MSG_MUX=11, LOAD_RG=1.
- MIX: MSG_MUX=10, LOAD_RG=1, COL_SEL=col. col increments each cycle; leaves MIX when col=MIXCOL_CYCLES-1, and col<=0.
- Decrypt order per round r=1..NR: SHIFT, SUB, ARK, then MIX if r<NR. rnd increments on SHIFT entry.
- Encrypt order per round r=1..NR: SUB, SHIFT, MIX if r<NR, then ARK. rnd increments on SUB entry.
- After ARK with rnd=NR -> DONE. Round 0 ARK is followed by the first round.
- Latency, LOAD to first DONE cycle: 2 + 3*NR + (NR-1)*MIXCOL_CYCLES cycles. NR=10, MC=1 gives 41.
- DONE: AES_DONE=1, LOAD_RG=0, so the result is held. Stays in DONE while AES_START=1; AES_START=0 -> IDLE.
- AES_START and MODE changes while BUSY are ignored.
- RESET mid-operation: IDLE on the next edge. No partial DONE.
- RK_IDX=0 and COL_SEL=0 whenever they are not meaningful.

Decomposition:
- aes_pkg: state enum, MSG_MUX encoding constants (MSG_ARK, MSG_SHIFT, MSG_MIX, MSG_SUB), legal NR constants (NR_128=10, NR_192=12, NR_256=14).
- One sub-module, aes_round_cnt: rnd/col counters with last_round and last_col terminal flags.
- aes_round_ctrl holds the FSM and output decode.

Test Plan:
- NR=10, MC=1, MODE=0, START held -> DONE asserted exactly 41 cycles after LOAD. RK_IDX over RK_VALID cycles = 10,9,...,0. MSG_MUX pattern per round = 01,11,00,10; final round has no 10.
- NR=14, MC=4, MODE=1 -> DONE 96 cycles after LOAD. RK_IDX = 0..14. Each MIX lasts 4 cycles with COL_SEL 0,1,2,3.
- NR=12, MC=2, MODE=1 -> latency 60. COL_SEL 0,1 per MIX. 11 MIX passes total.
- DONE handshake: START held 5 cycles past DONE -> AES_DONE high 5 cycles, LOAD_RG=0 throughout. START drop -> IDLE next cycle, AES_DONE=0.
- RESET asserted during round 5 ARK -> next cycle all outputs 0, BUSY=0. New START runs a full 41-cycle operation.
- START toggled and MODE flipped while BUSY -> sequence and cycle count unchanged, mode_q unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared types and constants for the AES round controller slice.
//   aes_state_e : controller state encoding
//   MSG_*       : MSG_MUX source select encoding for the state register input
//   NR_*        : legal round counts for AES-128/192/256
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARK   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_SUB   = 3'd4,
    ST_MIX   = 3'd5,
    ST_DONE  = 3'd6
  } aes_state_e;

  localparam logic [1:0] MSG_ARK   = 2'b00;
  localparam logic [1:0] MSG_SHIFT = 2'b01;
  localparam logic [1:0] MSG_MIX   = 2'b10;
  localparam logic [1:0] MSG_SUB   = 2'b11;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

endpackage

// File: rtl/aes_round_cnt.sv
// aes_round_cnt
// Round counter (rnd, 0..NR) and MixColumns slice counter (col, 0..MIXCOL_CYCLES-1).
// Ports:
//   CLK, RESET  : clock, synchronous active-high reset
//   rnd_clr     : clear rnd (start of a new operation)
//   rnd_inc     : advance rnd by one (entry into a new round)
//   col_inc     : advance col, wrapping to 0 after the last slice
//   rnd, col    : counter values
//   last_round  : rnd == NR
//   last_col    : col == MIXCOL_CYCLES-1
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int NR            = NR_128,
  parameter int MIXCOL_CYCLES = 1,
  parameter int RKI_W         = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rnd_clr,
  input  logic             rnd_inc,
  input  logic             col_inc,
  output logic [RKI_W-1:0] rnd,
  output logic [1:0]       col,
  output logic             last_round,
  output logic             last_col
);

  localparam logic [RKI_W-1:0] RND_LAST = RKI_W'(NR);
  localparam logic [1:0]       COL_LAST = 2'(MIXCOL_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RESET || rnd_clr) begin
      rnd <= '0;
    end else if (rnd_inc) begin
      rnd <= rnd + RKI_W'(1);
    end
  end

  // col self-wraps so MIX always exits with the slice counter back at 0
  always_ff @(posedge CLK) begin
    if (RESET) begin
      col <= '0;
    end else if (col_inc) begin
      col <= last_col ? 2'd0 : col + 2'd1;
    end
  end

  assign last_round = (rnd == RND_LAST);
  assign last_col   = (col == COL_LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Round sequencer for a shared AES encrypt/decrypt datapath.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   AES_START  : level request, sampled only in IDLE and DONE
//   MODE       : 1 = encrypt, 0 = decrypt; captured with AES_START in IDLE
//   AES_DONE   : result valid in the state register
//   BUSY       : high in every state except IDLE and DONE
//   LOAD_IN    : load state register from the input message
//   LOAD_RG    : state register write enable
//   MSG_MUX    : datapath source select (see aes_pkg MSG_*)
//   COL_SEL    : MixColumns slice index
//   RK_IDX     : round-key index into the external key-schedule store
//   RK_VALID   : RK_IDX is valid (ARK only)
//
// state | meaning
// IDLE  | waiting for AES_START
// LOAD  | message loaded into the state register
// ARK   | AddRoundKey with key RK_IDX
// SHIFT | (Inv)ShiftRows
// SUB   | (Inv)SubBytes
// MIX   | (Inv)MixColumns, one slice per cycle
// DONE  | result held until AES_START drops
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR            = NR_128,
  parameter int MIXCOL_CYCLES = 1,
  parameter int RKI_W         = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             AES_START,
  input  logic             MODE,
  output logic             AES_DONE,
  output logic             BUSY,
  output logic             LOAD_IN,
  output logic             LOAD_RG,
  output logic [1:0]       MSG_MUX,
  output logic [1:0]       COL_SEL,
  output logic [RKI_W-1:0] RK_IDX,
  output logic             RK_VALID
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if (MIXCOL_CYCLES != 1 && MIXCOL_CYCLES != 2 && MIXCOL_CYCLES != 4) begin : g_bad_mc
    $error("aes_round_ctrl: MIXCOL_CYCLES must be 1, 2 or 4");
  end
  if ((2 ** RKI_W) <= NR) begin : g_bad_rkiw
    $error("aes_round_ctrl: RKI_W too narrow for NR");
  end

  localparam logic [RKI_W-1:0] NR_L = RKI_W'(NR);

  aes_state_e       state;
  logic             mode_q;
  logic [RKI_W-1:0] rnd;
  logic [1:0]       col;
  logic             last_round;
  logic             last_col;
  logic             rnd_zero;
  logic             rnd_clr;
  logic             rnd_inc;
  logic             col_inc;

  assign rnd_zero = (rnd == '0);

  // rnd advances on entry to the first step of each round: SUB when
  // encrypting, SHIFT when decrypting (from ARK0 or from a MIX exit).
  always_comb begin
    rnd_clr = (state == ST_IDLE) && AES_START;
    rnd_inc = ((state == ST_ARK) && !last_round && (mode_q || rnd_zero)) ||
              ((state == ST_MIX) && last_col && !mode_q);
    col_inc = (state == ST_MIX);
  end

  aes_round_cnt #(
    .NR            (NR),
    .MIXCOL_CYCLES (MIXCOL_CYCLES),
    .RKI_W         (RKI_W)
  ) u_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .rnd_clr    (rnd_clr),
    .rnd_inc    (rnd_inc),
    .col_inc    (col_inc),
    .rnd        (rnd),
    .col        (col),
    .last_round (last_round),
    .last_col   (last_col)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (AES_START) begin
            state  <= ST_LOAD;
            mode_q <= MODE;
          end
        end
        ST_LOAD: state <= ST_ARK;
        // Decrypt: ARK0 opens round 1 with SHIFT; later ARKs feed MIX.
        ST_ARK: begin
          if (last_round)    state <= ST_DONE;
          else if (mode_q)   state <= ST_SUB;
          else if (rnd_zero) state <= ST_SHIFT;
          else               state <= ST_MIX;
        end
        ST_SUB:   state <= mode_q ? ST_SHIFT : ST_ARK;
        ST_SHIFT: begin
          if (!mode_q)        state <= ST_SUB;
          else if (last_round) state <= ST_ARK;
          else                 state <= ST_MIX;
        end
        ST_MIX: begin
          if (last_col) state <= mode_q ? ST_ARK : ST_SHIFT;
        end
        ST_DONE: begin
          if (!AES_START) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    AES_DONE = 1'b0;
    BUSY     = 1'b0;
    LOAD_IN  = 1'b0;
    LOAD_RG  = 1'b0;
    MSG_MUX  = MSG_ARK;
    COL_SEL  = 2'd0;
    RK_IDX   = '0;
    RK_VALID = 1'b0;
    case (state)
      ST_LOAD: begin
        BUSY    = 1'b1;
        LOAD_IN = 1'b1;
        LOAD_RG = 1'b1;
      end
      ST_ARK: begin
        BUSY     = 1'b1;
        LOAD_RG  = 1'b1;
        MSG_MUX  = MSG_ARK;
        RK_VALID = 1'b1;
        RK_IDX   = mode_q ? rnd : (NR_L - rnd);
      end
      ST_SHIFT: begin
        BUSY    = 1'b1;
        LOAD_RG = 1'b1;
        MSG_MUX = MSG_SHIFT;
      end
      ST_SUB: begin
        BUSY    = 1'b1;
        LOAD_RG = 1'b1;
        MSG_MUX = MSG_SUB;
      end
      ST_MIX: begin
        BUSY    = 1'b1;
        LOAD_RG = 1'b1;
        MSG_MUX = MSG_MIX;
        COL_SEL = col;
      end
      ST_DONE: AES_DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl
// Directed bench for aes_round_ctrl. Three instances cover NR/MIXCOL_CYCLES
// combinations 10/1, 14/4 and 12/2. A vector table drives whole operations;
// each busy cycle is compared against a round-by-round expected schedule,
// followed by latency and DONE handshake checks. A hand sequence covers
// reset in the middle of an operation.
// Sampled word layout: {DONE, BUSY, LOAD_IN, LOAD_RG, RK_VALID, MSG_MUX, COL_SEL, RK_IDX}
module tb_aes_round_ctrl;

  logic       CLK;
  logic       RESET;
  logic       mode;
  logic       start_v [3];
  logic       done_o  [3];
  logic       busy_o  [3];
  logic       ldin_o  [3];
  logic       ldrg_o  [3];
  logic [1:0] mux_o   [3];
  logic [1:0] col_o   [3];
  logic [3:0] rk_o    [3];
  logic       rkv_o   [3];

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    int d;
    bit mode;
    int nr;
    int mc;
    bit disturb;
    int hold;
    int exp_lat;
  } vec_t;

  vec_t vecs [6];
  logic [12:0] exp_q [$];

  localparam logic [12:0] DONE_W = 13'b1_0_0_0_0_00_00_0000;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  aes_round_ctrl #(.NR(10), .MIXCOL_CYCLES(1), .RKI_W(4)) dut0 (
    .CLK(CLK), .RESET(RESET), .AES_START(start_v[0]), .MODE(mode),
    .AES_DONE(done_o[0]), .BUSY(busy_o[0]), .LOAD_IN(ldin_o[0]), .LOAD_RG(ldrg_o[0]),
    .MSG_MUX(mux_o[0]), .COL_SEL(col_o[0]), .RK_IDX(rk_o[0]), .RK_VALID(rkv_o[0]));

  aes_round_ctrl #(.NR(14), .MIXCOL_CYCLES(4), .RKI_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .AES_START(start_v[1]), .MODE(mode),
    .AES_DONE(done_o[1]), .BUSY(busy_o[1]), .LOAD_IN(ldin_o[1]), .LOAD_RG(ldrg_o[1]),
    .MSG_MUX(mux_o[1]), .COL_SEL(col_o[1]), .RK_IDX(rk_o[1]), .RK_VALID(rkv_o[1]));

  aes_round_ctrl #(.NR(12), .MIXCOL_CYCLES(2), .RKI_W(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .AES_START(start_v[2]), .MODE(mode),
    .AES_DONE(done_o[2]), .BUSY(busy_o[2]), .LOAD_IN(ldin_o[2]), .LOAD_RG(ldrg_o[2]),
    .MSG_MUX(mux_o[2]), .COL_SEL(col_o[2]), .RK_IDX(rk_o[2]), .RK_VALID(rkv_o[2]));

  function automatic logic [12:0] smp(input int d);
    return {done_o[d], busy_o[d], ldin_o[d], ldrg_o[d], rkv_o[d],
            mux_o[d], col_o[d], rk_o[d]};
  endfunction

  function automatic logic [12:0] bw(input logic [1:0] mux, input logic ldin,
                                     input logic rkv, input int rk, input int col);
    return {1'b0, 1'b1, ldin, 1'b1, rkv, mux, 2'(col), 4'(rk)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Expected busy-cycle schedule from LOAD up to the last cycle before DONE.
  task automatic build(input bit m, input int nr, input int mc);
    exp_q.delete();
    exp_q.push_back(bw(2'b00, 1'b1, 1'b0, 0, 0));
    exp_q.push_back(bw(2'b00, 1'b0, 1'b1, m ? 0 : nr, 0));
    for (int r = 1; r <= nr; r++) begin
      if (m) begin
        exp_q.push_back(bw(2'b11, 1'b0, 1'b0, 0, 0));
        exp_q.push_back(bw(2'b01, 1'b0, 1'b0, 0, 0));
        if (r < nr)
          for (int c = 0; c < mc; c++) exp_q.push_back(bw(2'b10, 1'b0, 1'b0, 0, c));
        exp_q.push_back(bw(2'b00, 1'b0, 1'b1, r, 0));
      end else begin
        exp_q.push_back(bw(2'b01, 1'b0, 1'b0, 0, 0));
        exp_q.push_back(bw(2'b11, 1'b0, 1'b0, 0, 0));
        exp_q.push_back(bw(2'b00, 1'b0, 1'b1, nr - r, 0));
        if (r < nr)
          for (int c = 0; c < mc; c++) exp_q.push_back(bw(2'b10, 1'b0, 1'b0, 0, c));
      end
    end
  endtask

  task automatic run_op(input int vi, input vec_t v);
    int  c;
    bit  seen;
    build(v.mode, v.nr, v.mc);
    @(negedge CLK);
    start_v[v.d] = 1'b1;
    mode = v.mode;
    c = 0;
    seen = 1'b0;
    while (c <= 200) begin
      @(negedge CLK);
      if (done_o[v.d]) begin
        seen = 1'b1;
        break;
      end
      if (c < exp_q.size())
        chk($sformatf("v%0d seq c%0d", vi, c), 32'(smp(v.d)), 32'(exp_q[c]));
      if (v.disturb && c < v.exp_lat - 2) begin
        start_v[v.d] = 1'($urandom_range(0, 1));
        mode = ~mode;
      end else begin
        start_v[v.d] = 1'b1;
      end
      c++;
    end
    chk($sformatf("v%0d latency", vi), 32'(c), 32'(v.exp_lat));
    if (seen) begin
      for (int h = 0; h < v.hold; h++) begin
        if (h > 0) @(negedge CLK);
        chk($sformatf("v%0d done_hold h%0d", vi, h), 32'(smp(v.d)), 32'(DONE_W));
      end
    end
    start_v[v.d] = 1'b0;
    @(negedge CLK);
    chk($sformatf("v%0d idle_after", vi), 32'(smp(v.d)), 32'd0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{d: 0, mode: 1'b0, nr: 10, mc: 1, disturb: 1'b0, hold: 5, exp_lat: 41};
    vecs[1] = '{d: 1, mode: 1'b1, nr: 14, mc: 4, disturb: 1'b0, hold: 1, exp_lat: 96};
    vecs[2] = '{d: 2, mode: 1'b1, nr: 12, mc: 2, disturb: 1'b0, hold: 1, exp_lat: 60};
    vecs[3] = '{d: 0, mode: 1'b1, nr: 10, mc: 1, disturb: 1'b1, hold: 2, exp_lat: 41};
    vecs[4] = '{d: 2, mode: 1'b0, nr: 12, mc: 2, disturb: 1'b0, hold: 1, exp_lat: 60};
    vecs[5] = '{d: 1, mode: 1'b0, nr: 14, mc: 4, disturb: 1'b1, hold: 3, exp_lat: 96};

    RESET = 1'b1;
    mode  = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) chk($sformatf("reset dut%0d", i), 32'(smp(i)), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 6; i++) run_op(i, vecs[i]);

    // Reset during the round-5 ARK of a decrypt on the NR=10 instance.
    build(1'b0, 10, 1);
    @(negedge CLK);
    start_v[0] = 1'b1;
    mode = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge CLK);
      chk($sformatf("rst_seq c%0d", c), 32'(smp(0)), 32'(exp_q[c]));
    end
    chk("rst_at_ark5", 32'(smp(0)), 32'(bw(2'b00, 1'b0, 1'b1, 5, 0)));
    RESET = 1'b1;
    start_v[0] = 1'b0;
    @(negedge CLK);
    chk("rst_mid_outputs", 32'(smp(0)), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_stays_idle", 32'(smp(0)), 32'd0);
    rv = '{d: 0, mode: 1'b0, nr: 10, mc: 1, disturb: 1'b0, hold: 1, exp_lat: 41};
    run_op(6, rv);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
